// File: rtl/usb_multi_ep_protocol_ctrl.sv
// usb_multi_ep_protocol_ctrl
//   USB full-speed protocol sequencer for NUM_EP endpoints. Sits between the
//   RX decoder, TX encoder, shared data buffer and the AHB-Lite slave, and
//   enforces OUT / IN transfer ordering with per-endpoint DATA0/DATA1 toggles,
//   an endpoint range check and a host-handshake timeout after IN data.
//
// Ports
//   clk, n_rst            clock, asynchronous active-low reset
//   rx_packet[2:0]        decoded RX PID (IDLE,DATA0,OUT,IN,ACK,NAK,BAD,DATA1)
//   rx_endpoint[3:0]      endpoint of the last OUT/IN token
//   tx_done               TX finished the current packet (pulse)
//   buffer_reserved       AHB is filling the buffer for an IN transfer
//   tx_packet_data_size   bytes the AHB side intends to send
//   buffer_occupancy      bytes currently held in the buffer
//   rx_data_ready         OUT payload available to the AHB side
//   rx_transfer_active    OUT data phase in progress
//   rx_error / tx_error   sticky error flags, cleared when AHB reserves buffer
//   clear                 one-cycle buffer flush
//   tx_packet[1:0]        request to TX (IDLE,DATA,ACK,NAK), one-cycle pulse
//   tx_toggle             DATA0/DATA1 select for tx_packet=DATA
//   d_mode                endpoint is driving the bus
//   cur_ep[3:0]           endpoint of the transfer in progress
module usb_multi_ep_protocol_ctrl #(
   parameter int  NUM_EP     = 4,
   parameter int  BUF_DEPTH  = 64,
   parameter int  HS_TIMEOUT = 800,
   localparam int OW         = $clog2(BUF_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic [2:0]    rx_packet,
   input  logic [3:0]    rx_endpoint,
   input  logic          tx_done,
   input  logic          buffer_reserved,
   input  logic [OW-1:0] tx_packet_data_size,
   input  logic [OW-1:0] buffer_occupancy,
   output logic          rx_data_ready,
   output logic          rx_transfer_active,
   output logic          rx_error,
   output logic          tx_transfer_active,
   output logic          tx_error,
   output logic          clear,
   output logic [1:0]    tx_packet,
   output logic          tx_toggle,
   output logic          d_mode,
   output logic [3:0]    cur_ep
);
   localparam int         TW       = $clog2(HS_TIMEOUT);
   localparam int         EPW      = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
   localparam logic [4:0] NUM_EP_L = 5'(NUM_EP);

   localparam logic [2:0] PID_IDLE = 3'd0, PID_D0  = 3'd1, PID_OUT = 3'd2,
                          PID_IN   = 3'd3, PID_ACK = 3'd4, PID_NAK = 3'd5,
                          PID_BAD  = 3'd6, PID_D1  = 3'd7;
   localparam logic [1:0] TX_IDLE  = 2'd0, TX_DAT  = 2'd1, TX_ACK  = 2'd2,
                          TX_NAK   = 2'd3;

   typedef enum logic [3:0] {
      IDLE, RX_WAIT, RX_DATA, RX_ACK, RX_ACK_WAIT, DRAIN, AHB_STORE,
      TX_DATA, TX_WAIT_DONE, TX_WAIT_HS, NAK_START, NAK_WAIT
   } state_t;

   state_t            state_q, state_d, ret_q, ret_d;
   logic [3:0]        ep_q, ep_d;
   logic              dpid_q, dpid_d, dup_q, dup_d;
   logic [TW-1:0]     cnt_q, cnt_d;
   logic [NUM_EP-1:0] rx_tog_q, rx_tog_d, tx_tog_q, tx_tog_d;
   logic              rdy_q, rdy_d, rx_err_q, rx_err_d, tx_err_q, tx_err_d;
   logic              clr_q, clr_d, tog_q, tog_d, tx_act_q, tx_act_d;
   logic              rx_act_q, rx_act_d;
   logic [1:0]        pkt_q, pkt_d;

   logic is_tok, ep_ok, occ_zero, occ_full;
   assign is_tok   = (rx_packet == PID_OUT) || (rx_packet == PID_IN);
   assign ep_ok    = {1'b0, rx_endpoint} < NUM_EP_L;
   assign occ_zero = (buffer_occupancy == '0);
   assign occ_full = (buffer_occupancy == tx_packet_data_size);

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      ep_d     = ep_q;
      dpid_d   = dpid_q;
      dup_d    = dup_q;
      cnt_d    = cnt_q;
      rx_tog_d = rx_tog_q;
      tx_tog_d = tx_tog_q;
      rdy_d    = rdy_q;
      rx_err_d = rx_err_q;
      tx_err_d = tx_err_q;
      clr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_tok) ep_d = rx_endpoint;
            if (rx_packet == PID_OUT && ep_ok) begin
               state_d = RX_WAIT;
            end else if (rx_packet == PID_BAD || (is_tok && !ep_ok) ||
                         (rx_packet == PID_IN && !buffer_reserved)) begin
               rx_err_d = 1'b1;
               ret_d    = IDLE;
               state_d  = NAK_START;
            end else if (buffer_reserved) begin
               rx_err_d = 1'b0;
               tx_err_d = 1'b0;
               state_d  = AHB_STORE;
            end
         end
         RX_WAIT: begin
            if (rx_packet == PID_D0 || rx_packet == PID_D1) begin
               dpid_d  = rx_packet[2];   // DATA1 is the only data PID with bit 2 set
               state_d = RX_DATA;
            end else if (rx_packet == PID_BAD) begin
               clr_d   = 1'b1;
               ret_d   = IDLE;
               state_d = NAK_START;
            end
         end
         RX_DATA: begin
            if (rx_packet == PID_IDLE) begin
               state_d = RX_ACK;
               // The host retransmits if it missed our ACK; a stale PID is
               // still ACKed but its payload is flushed.
               if (dpid_q == rx_tog_q[ep_q[EPW-1:0]]) begin
                  rx_tog_d[ep_q[EPW-1:0]] = ~rx_tog_q[ep_q[EPW-1:0]];
                  rdy_d = 1'b1;
                  dup_d = 1'b0;
               end else begin
                  clr_d = 1'b1;
                  dup_d = 1'b1;
               end
            end else if (rx_packet == PID_BAD) begin
               clr_d    = 1'b1;
               rx_err_d = 1'b1;
               ret_d    = IDLE;
               state_d  = NAK_START;
            end
         end
         RX_ACK:      state_d = RX_ACK_WAIT;
         RX_ACK_WAIT: if (tx_done) state_d = dup_q ? IDLE : DRAIN;
         DRAIN: begin
            if (occ_zero) begin
               rdy_d   = 1'b0;
               state_d = IDLE;
            end else if (is_tok) begin
               rx_err_d = 1'b1;
               ret_d    = DRAIN;
               state_d  = NAK_START;
            end
         end
         AHB_STORE: begin
            if (is_tok) begin
               ep_d    = rx_endpoint;
               ret_d   = IDLE;
               state_d = (rx_packet == PID_IN && ep_ok && occ_full) ? TX_DATA : NAK_START;
            end
         end
         TX_DATA: state_d = TX_WAIT_DONE;
         TX_WAIT_DONE: begin
            if (tx_done) begin
               cnt_d   = TW'(HS_TIMEOUT - 1);
               state_d = TX_WAIT_HS;
            end
         end
         TX_WAIT_HS: begin
            // ACK is tested first so it wins over a coinciding expiry.
            if (rx_packet == PID_ACK) begin
               tx_tog_d[ep_q[EPW-1:0]] = ~tx_tog_q[ep_q[EPW-1:0]];
               state_d = IDLE;
            end else if (rx_packet == PID_NAK || cnt_q == '0) begin
               tx_err_d = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         NAK_START: state_d = NAK_WAIT;
         NAK_WAIT:  if (tx_done) state_d = ret_q;
         default:   state_d = IDLE;
      endcase

      // Outputs derived from the next state so they move with the state edge.
      tx_act_d = state_d inside {RX_ACK, RX_ACK_WAIT, TX_DATA, TX_WAIT_DONE,
                                 NAK_START, NAK_WAIT};
      rx_act_d = state_d inside {RX_WAIT, RX_DATA};
      case (state_d)
         RX_ACK:    pkt_d = TX_ACK;
         TX_DATA:   pkt_d = TX_DAT;
         NAK_START: pkt_d = TX_NAK;
         default:   pkt_d = TX_IDLE;
      endcase
      tog_d = (state_d == TX_DATA) && tx_tog_q[ep_d[EPW-1:0]];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         ret_q    <= IDLE;
         ep_q     <= '0;
         dpid_q   <= 1'b0;
         dup_q    <= 1'b0;
         cnt_q    <= '0;
         rx_tog_q <= '0;
         tx_tog_q <= '0;
         rdy_q    <= 1'b0;
         rx_err_q <= 1'b0;
         tx_err_q <= 1'b0;
         clr_q    <= 1'b0;
         tog_q    <= 1'b0;
         tx_act_q <= 1'b0;
         rx_act_q <= 1'b0;
         pkt_q    <= TX_IDLE;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         ep_q     <= ep_d;
         dpid_q   <= dpid_d;
         dup_q    <= dup_d;
         cnt_q    <= cnt_d;
         rx_tog_q <= rx_tog_d;
         tx_tog_q <= tx_tog_d;
         rdy_q    <= rdy_d;
         rx_err_q <= rx_err_d;
         tx_err_q <= tx_err_d;
         clr_q    <= clr_d;
         tog_q    <= tog_d;
         tx_act_q <= tx_act_d;
         rx_act_q <= rx_act_d;
         pkt_q    <= pkt_d;
      end
   end

   assign rx_data_ready      = rdy_q;
   assign rx_transfer_active = rx_act_q;
   assign rx_error           = rx_err_q;
   assign tx_transfer_active = tx_act_q;
   assign tx_error           = tx_err_q;
   assign clear              = clr_q;
   assign tx_packet          = pkt_q;
   assign tx_toggle          = tog_q;
   assign d_mode             = tx_act_q;
   assign cur_ep             = ep_q;
endmodule

// File: tb/tb_usb_multi_ep_protocol_ctrl.sv
// Bench for usb_multi_ep_protocol_ctrl: directed walk through the protocol
// scenarios with literal expectations, then phase-guided random stimulus.
// A transaction-level model tracks where the exchange is and what the DUT
// must be presenting; every cycle all outputs are compared against it.
module tb_usb_multi_ep_protocol_ctrl;
   localparam int NUM_EP = 4, BUF_DEPTH = 64, HS_TIMEOUT = 16;
   localparam int OW = $clog2(BUF_DEPTH + 1);
   localparam logic [2:0] P_IDLE = 3'd0, P_D0 = 3'd1, P_OUT = 3'd2, P_IN = 3'd3,
                          P_ACK = 3'd4, P_NAK = 3'd5, P_BAD = 3'd6, P_D1 = 3'd7;
   // model phases of the exchange
   localparam int M_IDLE = 0, M_RXW = 1, M_RXD = 2, M_ACK = 3, M_ACKW = 4,
                  M_DRAIN = 5, M_STORE = 6, M_TXD = 7, M_TXW = 8, M_HS = 9,
                  M_NAKS = 10, M_NAKW = 11;

   logic          clk = 1'b0, n_rst = 1'b0;
   logic [2:0]    rx_packet = P_IDLE;
   logic [3:0]    rx_endpoint = '0;
   logic          tx_done = 1'b0, buffer_reserved = 1'b0;
   logic [OW-1:0] tx_packet_data_size = '0, buffer_occupancy = '0;
   logic          rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active;
   logic          tx_error, clear, tx_toggle, d_mode;
   logic [1:0]    tx_packet;
   logic [3:0]    cur_ep;

   int n_checks = 0, n_errors = 0;

   // model state
   int m_ph, m_ret, m_waited, m_ep;
   bit m_rtog[16], m_ttog[16];
   bit m_dpid, m_dup, m_rdy, m_rerr, m_terr, m_clear;

   usb_multi_ep_protocol_ctrl #(.NUM_EP(NUM_EP), .BUF_DEPTH(BUF_DEPTH), .HS_TIMEOUT(HS_TIMEOUT)) dut (
      .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_endpoint(rx_endpoint),
      .tx_done(tx_done), .buffer_reserved(buffer_reserved),
      .tx_packet_data_size(tx_packet_data_size), .buffer_occupancy(buffer_occupancy),
      .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
      .rx_error(rx_error), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
      .clear(clear), .tx_packet(tx_packet), .tx_toggle(tx_toggle), .d_mode(d_mode),
      .cur_ep(cur_ep));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph = M_IDLE; m_ret = M_IDLE; m_waited = 0; m_ep = 0;
      m_dpid = 0; m_dup = 0; m_rdy = 0; m_rerr = 0; m_terr = 0; m_clear = 0;
      for (int i = 0; i < 16; i++) begin m_rtog[i] = 0; m_ttog[i] = 0; end
   endtask

   task automatic go_nak(input int ret);
      m_ret = ret;
      m_ph  = M_NAKS;
   endtask

   // One clock of the exchange, using the inputs the DUT saw at the edge.
   task automatic model_step();
      bit tok, good;
      m_clear = 0;
      if (!n_rst) begin model_reset(); return; end
      tok  = (rx_packet == P_OUT) || (rx_packet == P_IN);
      good = rx_endpoint < NUM_EP;
      case (m_ph)
         M_IDLE: begin
            if (tok) m_ep = rx_endpoint;
            if (rx_packet == P_OUT && good) m_ph = M_RXW;
            else if (rx_packet == P_BAD || (tok && !good) || (rx_packet == P_IN && !buffer_reserved)) begin
               m_rerr = 1; go_nak(M_IDLE);
            end else if (buffer_reserved) begin
               m_ph = M_STORE; m_rerr = 0; m_terr = 0;
            end
         end
         M_RXW: begin
            if (rx_packet == P_D0 || rx_packet == P_D1) begin
               m_dpid = (rx_packet == P_D1); m_ph = M_RXD;
            end else if (rx_packet == P_BAD) begin
               m_clear = 1; go_nak(M_IDLE);
            end
         end
         M_RXD: begin
            if (rx_packet == P_IDLE) begin
               m_ph = M_ACK;
               if (m_dpid == m_rtog[m_ep]) begin
                  m_rtog[m_ep] = !m_rtog[m_ep]; m_rdy = 1; m_dup = 0;
               end else begin
                  m_clear = 1; m_dup = 1;
               end
            end else if (rx_packet == P_BAD) begin
               m_clear = 1; m_rerr = 1; go_nak(M_IDLE);
            end
         end
         M_ACK:  m_ph = M_ACKW;
         M_ACKW: if (tx_done) m_ph = m_dup ? M_IDLE : M_DRAIN;
         M_DRAIN: begin
            if (buffer_occupancy == 0) begin m_rdy = 0; m_ph = M_IDLE; end
            else if (tok) begin m_rerr = 1; go_nak(M_DRAIN); end
         end
         M_STORE: begin
            if (tok) begin
               m_ep = rx_endpoint;
               if (rx_packet == P_IN && good && buffer_occupancy == tx_packet_data_size) m_ph = M_TXD;
               else go_nak(M_IDLE);
            end
         end
         M_TXD: m_ph = M_TXW;
         M_TXW: if (tx_done) begin m_ph = M_HS; m_waited = 0; end
         M_HS: begin
            m_waited++;
            if (rx_packet == P_ACK) begin m_ttog[m_ep] = !m_ttog[m_ep]; m_ph = M_IDLE; end
            else if (rx_packet == P_NAK || m_waited == HS_TIMEOUT) begin m_terr = 1; m_ph = M_IDLE; end
         end
         M_NAKS: m_ph = M_NAKW;
         M_NAKW: if (tx_done) m_ph = m_ret;
         default: m_ph = M_IDLE;
      endcase
   endtask

   task automatic compare_all();
      int pkt;
      bit txa;
      pkt = (m_ph == M_TXD) ? 1 : (m_ph == M_ACK) ? 2 : (m_ph == M_NAKS) ? 3 : 0;
      txa = (m_ph == M_ACK) || (m_ph == M_ACKW) || (m_ph == M_TXD) || (m_ph == M_TXW) ||
            (m_ph == M_NAKS) || (m_ph == M_NAKW);
      check("rx_data_ready", rx_data_ready, m_rdy);
      check("rx_transfer_active", rx_transfer_active, (m_ph == M_RXW) || (m_ph == M_RXD));
      check("rx_error", rx_error, m_rerr);
      check("tx_transfer_active", tx_transfer_active, txa);
      check("d_mode", d_mode, txa);
      check("tx_error", tx_error, m_terr);
      check("clear", clear, m_clear);
      check("tx_packet", tx_packet, pkt);
      if (pkt == 1) check("tx_toggle", tx_toggle, m_ttog[m_ep]);
      check("cur_ep", cur_ep, m_ep);
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      compare_all();
      tx_done = 1'b0;
   endtask

   task automatic drive(input logic [2:0] p, input logic [3:0] e);
      rx_packet   = p;
      rx_endpoint = e;
   endtask

   task automatic rand_inputs();
      int r;
      r = $urandom_range(0, 99);
      rx_endpoint = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      tx_done = ($urandom_range(0, 3) == 0);
      buffer_reserved = ($urandom_range(0, 2) == 0);
      tx_packet_data_size = OW'($urandom_range(0, BUF_DEPTH));
      buffer_occupancy = ($urandom_range(0, 2) != 0) ? tx_packet_data_size : OW'($urandom_range(0, BUF_DEPTH));
      case (m_ph)
         M_RXW:   rx_packet = (r < 45) ? P_D0 : (r < 90) ? P_D1 : (r < 95) ? P_BAD : P_IDLE;
         M_RXD:   rx_packet = (r < 40) ? P_D0 : (r < 85) ? P_IDLE : (r < 93) ? P_BAD : P_OUT;
         M_HS:    rx_packet = (r < 6) ? P_ACK : (r < 10) ? P_NAK : P_IDLE;
         M_STORE: rx_packet = (r < 50) ? P_IN : (r < 60) ? P_OUT : (r < 65) ? P_BAD : P_IDLE;
         M_DRAIN: begin
            rx_packet = (r < 8) ? P_OUT : (r < 15) ? P_IN : P_IDLE;
            buffer_occupancy = ($urandom_range(0, 3) != 0) ? OW'($urandom_range(1, BUF_DEPTH)) : '0;
         end
         default: rx_packet = (r < 30) ? P_OUT : (r < 45) ? P_IN : (r < 50) ? P_BAD :
                              (r < 55) ? P_ACK : (r < 60) ? P_D0 : P_IDLE;
      endcase
   endtask

   initial begin
      model_reset();
      tick(); tick();
      check("reset tx_packet", tx_packet, 0);
      check("reset d_mode", d_mode, 0);
      check("reset rx_data_ready", rx_data_ready, 0);
      check("reset cur_ep", cur_ep, 0);
      n_rst = 1'b1;

      // OUT ep2 DATA0: fresh data accepted, then drained
      buffer_occupancy = 7'd10;
      drive(P_OUT, 4'd2); tick();
      check("out rx_active", rx_transfer_active, 1);
      check("out cur_ep", cur_ep, 2);
      drive(P_D0, 4'd0); tick();
      drive(P_IDLE, 4'd0); tick();
      check("ack pkt", tx_packet, 2);
      check("ack ready", rx_data_ready, 1);
      tick();
      check("ack one-shot", tx_packet, 0);
      tx_done = 1'b1; tick();
      tick();
      buffer_occupancy = '0; tick();
      check("drain ready", rx_data_ready, 0);

      // repeated DATA0 on ep2 is a duplicate
      buffer_occupancy = 7'd10;
      drive(P_OUT, 4'd2); tick();
      drive(P_D0, 4'd0); tick();
      drive(P_IDLE, 4'd0); tick();
      check("dup pkt", tx_packet, 2);
      check("dup clear", clear, 1);
      check("dup ready", rx_data_ready, 0);
      tick();
      tx_done = 1'b1; tick();
      // back in IDLE (not DRAIN): next OUT is accepted, DATA1 is fresh
      drive(P_OUT, 4'd2); tick();
      check("dup ret idle", rx_transfer_active, 1);
      drive(P_D1, 4'd0); tick();
      drive(P_IDLE, 4'd0); tick();
      check("d1 accept", rx_data_ready, 1);
      check("d1 no clear", clear, 0);
      tick();
      tx_done = 1'b1; tick();
      buffer_occupancy = '0; tick();

      // IN ep1 with full buffer, host ACKs, toggle advances
      buffer_reserved = 1'b1; tx_packet_data_size = 7'd8; buffer_occupancy = 7'd8;
      tick();
      drive(P_IN, 4'd1); tick();
      check("in data pkt", tx_packet, 1);
      check("in toggle0", tx_toggle, 0);
      drive(P_IDLE, 4'd0); tick();
      tx_done = 1'b1; tick();
      check("hs d_mode", d_mode, 0);
      drive(P_ACK, 4'd0); tick();
      drive(P_IDLE, 4'd0); tick();
      drive(P_IN, 4'd1); tick();
      check("in toggle1", tx_toggle, 1);

      // no handshake: timeout exactly HS_TIMEOUT cycles after tx_done
      drive(P_IDLE, 4'd0); tick();
      buffer_reserved = 1'b0;
      tx_done = 1'b1; tick();
      for (int k = 1; k <= HS_TIMEOUT; k++) begin
         tick();
         if (k == HS_TIMEOUT - 1) check("timeout early", tx_error, 0);
      end
      check("timeout fire", tx_error, 1);
      buffer_reserved = 1'b1; tick();
      check("store clears tx_error", tx_error, 0);
      drive(P_IN, 4'd1); tick();
      check("toggle kept after timeout", tx_toggle, 1);
      drive(P_IDLE, 4'd0); tick();
      tx_done = 1'b1; tick();
      drive(P_NAK, 4'd0); tick();
      check("nak tx_error", tx_error, 1);
      buffer_reserved = 1'b0;
      drive(P_IDLE, 4'd0); tick();

      // OUT to out-of-range endpoint
      drive(P_OUT, 4'd5); tick();
      check("bad ep nak", tx_packet, 3);
      check("bad ep rx_error", rx_error, 1);
      check("bad ep cur_ep", cur_ep, 5);
      drive(P_IDLE, 4'd0); tick();
      tx_done = 1'b1; tick();
      check("bad ep idle", d_mode, 0);

      // DATA1 then BAD, reset while waiting for the NAK
      drive(P_OUT, 4'd0); tick();
      drive(P_D1, 4'd0); tick();
      drive(P_BAD, 4'd0); tick();
      check("bad data nak", tx_packet, 3);
      check("bad data clear", clear, 1);
      check("bad data rx_error", rx_error, 1);
      drive(P_IDLE, 4'd0); tick();
      n_rst = 1'b0; model_reset();
      #1;
      check("arst d_mode", d_mode, 0);
      check("arst rx_error", rx_error, 0);
      check("arst tx_active", tx_transfer_active, 0);
      check("arst cur_ep", cur_ep, 0);
      tick();
      n_rst = 1'b1;
      // tx_tog[1] was 1 before reset
      buffer_reserved = 1'b1; tx_packet_data_size = 7'd4; buffer_occupancy = 7'd4;
      tick();
      drive(P_IN, 4'd1); tick();
      check("toggle reset", tx_toggle, 0);
      drive(P_IDLE, 4'd0); tick();
      tx_done = 1'b1; tick();
      drive(P_ACK, 4'd0); tick();
      buffer_reserved = 1'b0;
      drive(P_IDLE, 4'd0); tick();

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            n_rst = 1'b0;
            model_reset();
         end else begin
            n_rst = 1'b1;
         end
         rand_inputs();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/usb_multi_ep_protocol_ctrl.md
# usb_multi_ep_protocol_ctrl

Parametrised multi-endpoint USB full-speed protocol controller that enforces transfer sequences between the RX decoder, TX encoder, shared data buffer and AHB-Lite slave. It generalises the single-endpoint controller with per-endpoint DATA0/DATA1 toggle tracking and a configurable buffer depth. It also adds an endpoint-range check and a handshake timeout counter. It sits between usb_rx, usb_tx, the data buffer and the AHB-Lite slave.

## Interface
- NUM_EP, 4, number of supported endpoints (1-16)
- BUF_DEPTH, 64, data buffer capacity in bytes; OW = $clog2(BUF_DEPTH+1)
- HS_TIMEOUT, 800, cycles to wait for host ACK/NAK after TX data before timeout (≥2)

- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- rx_packet  in  3  RX PID: 0 IDLE, 1 DATA0, 2 OUT, 3 IN, 4 ACK, 5 NAK, 6 BAD, 7 DATA1
- rx_endpoint  in  4  endpoint field of the last token; valid when rx_packet is OUT/IN
- tx_done  in  1  one-cycle pulse: TX finished current packet
- buffer_reserved  in  1  AHB is filling buffer for an IN transfer
- tx_packet_data_size  in  OW  bytes AHB intends to send
- buffer_occupancy  in  OW  bytes currently in buffer
- rx_data_ready  out  1  OUT data valid in buffer for AHB
- rx_transfer_active  out  1  OUT data phase in progress
- rx_error  out  1  sticky: last OUT rejected / bad packet / bad endpoint
- tx_transfer_active  out  1  TX owns the bus
- tx_error  out  1  sticky: last IN transfer NAKed or timed out
- clear  out  1  one-cycle buffer flush
- tx_packet  out  2  to TX: 0 IDLE, 1 DATA, 2 ACK, 3 NAK; non-IDLE for exactly one cycle
- tx_toggle  out  1  DATA PID select when tx_packet=DATA (0 DATA0, 1 DATA1)
- d_mode  out  1  1 = endpoint driving bus
- cur_ep  out  4  endpoint of the transfer in progress

## Operation
- Per-endpoint registers rx_tog[NUM_EP] and tx_tog[NUM_EP], reset 0. ep_lat latches rx_endpoint on every OUT/IN token accepted in IDLE or AHB_STORE.
- States: IDLE, RX_WAIT, RX_DATA, RX_ACK, RX_ACK_WAIT, DRAIN, AHB_STORE, TX_DATA, TX_WAIT_DONE, TX_WAIT_HS, NAK_START, NAK_WAIT.
- IDLE:
  - OUT with ep<NUM_EP → RX_WAIT.
  - OUT/IN with ep≥NUM_EP, IN without buffer_reserved, or BAD → NAK_START with rx_error=1.
  - buffer_reserved → AHB_STORE.
- RX_WAIT:
  - DATA0/DATA1 → RX_DATA. Latch the PID bit as dpid.
  - BAD → NAK_START with clear=1.
- RX_DATA:
  - IDLE → RX_ACK.
  - BAD → NAK_START with clear=1 and rx_error=1.
- RX_ACK:
  - Issue tx_packet=ACK.
  - If dpid==rx_tog[ep]: flip rx_tog[ep] and set rx_data_ready=1.
  - Else (duplicate): pulse clear=1, rx_data_ready unchanged, toggle unchanged.
  - → RX_ACK_WAIT.
- RX_ACK_WAIT: tx_done → DRAIN (or IDLE if duplicate).
- DRAIN:
  - occupancy==0 → IDLE and rx_data_ready=0.
  - OUT/IN token → NAK_START with rx_error=1, then return to DRAIN.
- AHB_STORE:
  - Clear rx_error/tx_error on entry.
  - IN with ep<NUM_EP and occupancy==tx_packet_data_size → TX_DATA.
  - IN short, any OUT, or bad ep → NAK_START.
- TX_DATA: tx_packet=DATA, tx_toggle=tx_tog[ep] → TX_WAIT_DONE.
- TX_WAIT_DONE: tx_done → TX_WAIT_HS. Load the timeout counter with HS_TIMEOUT-1.
- TX_WAIT_HS:
  - ACK → flip tx_tog[ep] → IDLE.
  - NAK, or counter reaching 0 → tx_error=1 → IDLE, toggle unchanged.
- NAK_START: tx_packet=NAK → NAK_WAIT.
- NAK_WAIT: tx_done → return state (IDLE or DRAIN).
- tx_transfer_active=d_mode=1 in RX_ACK, RX_ACK_WAIT, TX_DATA, TX_WAIT_DONE, NAK_START, NAK_WAIT; 0 elsewhere.
- rx_transfer_active=1 in RX_WAIT and RX_DATA.

## Timing
- All outputs registered and computed from next state, so an output changes on the same edge the state is entered.
- Reset values: every output 0, all toggles 0, state IDLE, cur_ep 0.
- Token to first response: OUT good data IDLE → ACK issued 1 cycle later. IN with full buffer → DATA issued 1 cycle after token.
- Timeout counter is OW-independent, width $clog2(HS_TIMEOUT). The timeout fires exactly HS_TIMEOUT cycles after the tx_done edge.
- If ACK and timeout expiry coincide, ACK wins.
- If tx_done and a new token arrive in the same cycle, the token is ignored.
- Reset mid-transfer aborts immediately and clears all toggles.
- tx_done outside wait states is ignored.

## Test plan
- OUT ep2, DATA0, IDLE → ACK pulse, rx_data_ready=1, rx_tog[2]=1; occupancy→0 → IDLE, rx_data_ready=0.
- Repeat OUT ep2 with DATA0 (duplicate) → ACK, clear pulse, rx_data_ready stays 0, rx_tog[2] stays 1.
- buffer_reserved, size=occupancy=8, IN ep1 → DATA with tx_toggle=0; host ACK → tx_tog[1]=1; next IN → tx_toggle=1.
- IN ep1 and no handshake for HS_TIMEOUT cycles → tx_error=1, tx_tog[1] unchanged, IDLE.
- OUT ep5 with NUM_EP=4 → NAK issued, rx_error=1, back to IDLE after tx_done.
- DATA1 then BAD → NAK, clear pulse, rx_error=1; assert n_rst mid-NAK_WAIT → all outputs 0, toggles 0.
